// File: rtl/reg_file_wb.sv
// 32-entry register file with self-clearing init sequencer and two async read ports.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file_wb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              ready
);

    localparam int unsigned NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] mem [NREG];
    logic              wr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            idx   <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (state == INIT && idx == LAST_IDX) begin
            state_next = RUN;
        end
    end

    always_comb begin
        ready = (state == RUN);
    end

    // Architectural write: RUN only, never on a reset edge, r0 discarded.
    assign wr_en = ready && !rst && we && (waddr != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                mem[idx] <= '0;
            end else if (wr_en) begin
                mem[waddr] <= wdata;
            end
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (ready) begin
            if (raddr1 != '0) begin
                rdata1 = mem[raddr1];
            end
            if (raddr2 != '0) begin
                rdata2 = mem[raddr2];
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_en && waddr == raddr1) begin
                rdata1 = wdata;
            end
            if (wr_en && waddr == raddr2) begin
                rdata2 = wdata;
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb (base build or REGFILE_BYPASS_EN).
module tb_reg_file_wb;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        ready;

    int unsigned n_checks;
    int unsigned n_fail;

    reg_file_wb #(
        .DATA_W(32),
        .ADDR_W(5)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr1(raddr1),
        .raddr2(raddr2),
        .rdata1(rdata1),
        .rdata2(rdata2),
        .ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles until ready rises; read port 1 must stay zero meanwhile.
    task automatic wait_ready(input string name, input int unsigned exp_cycles);
        int unsigned n;
        n = 0;
        while (!ready && n < 40) begin
            n_checks++;
            if (rdata1 !== 32'h0) begin
                $display("FAIL %s_rdata_zero: cycle %0d rdata1=%h required 00000000", name, n, rdata1);
                n_fail++;
            end
            tick();
            n++;
        end
        n_checks++;
        if (n != exp_cycles || ready !== 1'b1) begin
            $display("FAIL %s_latency: cycles=%0d ready=%b required cycles=%0d ready=1", name, n, ready, exp_cycles);
            n_fail++;
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = 5'd5; raddr2 = 5'd31;
        tick();
        rst = 1'b0;
        n_checks++;
        if (ready !== 1'b0 || rdata2 !== 32'h0) begin
            $display("FAIL reset_state: ready=%b rdata2=%h required ready=0 rdata2=00000000", ready, rdata2);
            n_fail++;
        end
        wait_ready("init", 32);
    endtask

    task automatic test_basic();
        write_reg(5'd5, 32'hDEADBEEF);
        write_reg(5'd31, 32'h12345678);
        raddr1 = 5'd5; raddr2 = 5'd31;
        #1;
        n_checks++;
        if (rdata1 !== 32'hDEADBEEF || rdata2 !== 32'h12345678) begin
            $display("FAIL basic_rw: rdata1=%h rdata2=%h required deadbeef 12345678", rdata1, rdata2);
            n_fail++;
        end
        raddr2 = 5'd5;
        #1;
        n_checks++;
        if (rdata2 !== 32'hDEADBEEF || rdata1 !== 32'hDEADBEEF) begin
            $display("FAIL same_addr: rdata1=%h rdata2=%h required deadbeef deadbeef", rdata1, rdata2);
            n_fail++;
        end
        raddr1 = 5'd6;
        #1;
        n_checks++;
        if (rdata1 !== 32'h0) begin
            $display("FAIL untouched_reg: rdata1=%h required 00000000", rdata1);
            n_fail++;
        end
    endtask

    task automatic test_r0();
        write_reg(5'd0, 32'hFFFFFFFF);
        raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        n_checks++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
            $display("FAIL r0_zero: rdata1=%h rdata2=%h required 00000000", rdata1, rdata2);
            n_fail++;
        end
        // Forwarding must never apply to r0 either.
        we = 1'b1; waddr = 5'd0; wdata = 32'hCAFEF00D;
        #1;
        n_checks++;
        if (rdata1 !== 32'h0) begin
            $display("FAIL r0_no_bypass: rdata1=%h required 00000000", rdata1);
            n_fail++;
        end
        tick();
        we = 1'b0;
    endtask

    task automatic test_read_during_write();
        logic [31:0] exp_same;
        write_reg(5'd7, 32'h1);
        we = 1'b1; waddr = 5'd7; wdata = 32'h2; raddr1 = 5'd7; raddr2 = 5'd5;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h2;
`else
        exp_same = 32'h1;
`endif
        n_checks++;
        if (rdata1 !== exp_same) begin
            $display("FAIL rdw_before_edge: rdata1=%h required %h", rdata1, exp_same);
            n_fail++;
        end
        n_checks++;
        if (rdata2 !== 32'hDEADBEEF) begin
            $display("FAIL rdw_other_port: rdata2=%h required deadbeef", rdata2);
            n_fail++;
        end
        tick();
        we = 1'b0;
        #1;
        n_checks++;
        if (rdata1 !== 32'h2) begin
            $display("FAIL rdw_after_edge: rdata1=%h required 00000002", rdata1);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_run();
        raddr1 = 5'd5; raddr2 = 5'd7;
        rst = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h55;
        tick();
        rst = 1'b0; we = 1'b0;
        n_checks++;
        if (ready !== 1'b0 || rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
            $display("FAIL mid_run_reset: ready=%b rdata1=%h rdata2=%h required 0 00000000 00000000", ready, rdata1, rdata2);
            n_fail++;
        end
        wait_ready("mid_run", 32);
        raddr2 = 5'd9;
        #1;
        n_checks++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
            $display("FAIL cleared_after_reset: r5=%h r9=%h required 00000000", rdata1, rdata2);
            n_fail++;
        end
    endtask

    task automatic test_write_during_init();
        write_reg(5'd3, 32'h77);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        write_reg(5'd3, 32'hAA);
        wait_ready("init_write", 21);
        raddr1 = 5'd3;
        #1;
        n_checks++;
        if (rdata1 !== 32'h0) begin
            $display("FAIL init_write_ignored: r3=%h required 00000000", rdata1);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_init();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready("mid_init", 32);
        write_reg(5'd12, 32'hA5A5A5A5);
        raddr1 = 5'd12; raddr2 = 5'd31;
        #1;
        n_checks++;
        if (rdata1 !== 32'hA5A5A5A5 || rdata2 !== 32'h0) begin
            $display("FAIL post_restart_rw: rdata1=%h rdata2=%h required a5a5a5a5 00000000", rdata1, rdata2);
            n_fail++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_r0();
        test_read_during_write();
        test_reset_mid_run();
        test_write_during_init();
        test_reset_mid_init();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 32-entry general-purpose register file that consumes the writeback path's select outputs.
- Write address comes from the 5-bit destination-register select. Write data comes from the 32-bit writeback data select.
- Two asynchronous read ports feed the operand path: ALU input select and branch compare.
- After reset, a built-in init sequencer clears the array one entry per cycle and flags readiness.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; number of entries NREG = 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- we  input  1  write enable from control.
- waddr  input  ADDR_W  write register index (destination-select output).
- wdata  input  DATA_W  write data (writeback-select output).
- raddr1  input  ADDR_W  read port 1 index.
- raddr2  input  ADDR_W  read port 2 index.
- rdata1  output  DATA_W  read port 1 data, combinational.
- rdata2  output  DATA_W  read port 2 data, combinational.
- ready  output  1  high once the array is initialised.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - On any edge with rst=1: state<=INIT, idx<=0, ready<=0.
  - Array contents are not cleared by the reset edge itself.
- States:
  - INIT: each edge writes mem[idx]<=0 and idx<=idx+1. On the edge where idx==NREG-1, state<=RUN and ready<=1.
  - RUN: normal operation; stays in RUN until rst.
- Init latency: reset sampled at edge k clears entries 0..NREG-1 at edges k+1..k+NREG; ready=1 after edge k+NREG (NREG=32 cycles).
- Reset mid-INIT or mid-RUN: sequence restarts from idx=0; ready drops on that same edge.
- Writes:
  - Occur in RUN only, at the rising edge with we=1: mem[waddr]<=wdata.
  - Writes with waddr==0 are discarded.
  - we during INIT or with rst=1 is ignored; no deferred write.
- Reads:
  - rdata1/2 return mem[raddr] combinationally.
  - raddr==0 always returns 0.
  - While ready=0, both read ports return 0 regardless of address.
- Read-during-write, base build: reads return the old contents until the edge; the new value is visible after the write edge.
- Both ports may address the same register; both return identical data.
- Widths: no arithmetic. idx is ADDR_W bits and wraps only at the INIT->RUN transition, never beyond.
- Entry 0 is zero-forced on read; its storage may hold anything.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: adds write-through forwarding. In RUN, if we=1 and waddr!=0 and waddr==raddrN, then rdataN=wdata in the same cycle. This covers write-then-read within a single cycle, for a read-after-writeback hazard.
- Not defined: no forwarding; old contents are returned until the edge.
- Either way: no effect while ready=0 or for address 0.

Test Plan:
- Init: pulse rst for 1 cycle, then hold we=0 -> ready=0 for exactly 32 cycles, then ready=1. rdata1 at any address = 0x00000000 throughout.
- Basic write/read: after ready, write 0xDEADBEEF to r5 and 0x12345678 to r31. Then raddr1=5, raddr2=31 -> 0xDEADBEEF, 0x12345678.
- r0: we=1, waddr=0, wdata=0xFFFFFFFF -> raddr1=0 reads 0x00000000 next cycle.
- Same-cycle read/write on r7 (old 0x1, new 0x2):
  - Base build: rdata1=0x1 before the edge, 0x2 after.
  - With REGFILE_BYPASS_EN: rdata1=0x2 in the same cycle.
- Reset mid-operation: with r5=0xDEADBEEF in RUN, assert rst -> ready=0 next cycle and reads=0. After 32 cycles, ready=1 and r5 reads 0x00000000.
- Write during INIT: we=1, waddr=3, wdata=0xAA at cycle 10 of INIT -> after ready, r3 reads 0x00000000.
